pc_gen: RTL
===========

Name: pc_gen

Overview:
- Parametrised program-counter generator for the RV32I core. Successor to the 8-bit PCCount.
- Produces the fetch address each cycle, with a valid/ready handshake to instruction fetch.
- Next-PC sources: sequential +4, PC-relative branch, JALR absolute jump, trap vector.
- Detects misaligned redirect targets and parks in a fault state until the trap is taken.

Parameters:
XLEN, 32, address width in bits (≥8)
RESET_VECTOR, 'h0000_0000, PC value loaded by reset (must be 4-byte aligned)
TRAP_VECTOR, 'h0000_0100, PC value loaded on trap (must be 4-byte aligned)
HIST_DEPTH, 4, entries in the redirect history buffer (power of 2; optional feature only)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  hold the PC (suppresses sequential advance only)
fetch_ready  in  1  fetch accepts the current pc this cycle
branch_taken  in  1  resolved taken branch or JAL
branch_pc  in  XLEN  PC of the branch instruction
branch_offset  in  XLEN  sign-extended immediate
jalr  in  1  JALR resolved
jalr_base  in  XLEN  rs1 value
jalr_offset  in  XLEN  sign-extended immediate
trap  in  1  enter trap handler
pc  out  XLEN  current fetch address
pc_valid  out  1  pc is a legal fetch request
pc_plus4  out  XLEN  pc+4 (combinational, link value)
misalign  out  1  misaligned-target fault pending
misalign_addr  out  XLEN  offending target address
hist_idx  in  log2(HIST_DEPTH)  history read index (feature only)
hist_data  out  2*XLEN  {source_pc, target} (feature only)

Behaviour:
- States: BOOT, RUN, FAULT.
- Reset: pc=RESET_VECTOR, state=BOOT, pc_valid=0, misalign=0, misalign_addr=0, history cleared.
- rst mid-operation overrides every other input in the same cycle.
- BOOT -> RUN after exactly one cycle. pc_valid=1 from the first RUN cycle. This gives a one-cycle reset-to-fetch latency.
- Next-PC priority, in RUN: trap > jalr > branch_taken > sequential.
- trap: pc<=TRAP_VECTOR. Honoured in every state. Leaving FAULT via trap clears misalign.
- jalr target = (jalr_base + jalr_offset) & ~1.
- Branch target = branch_pc + branch_offset.
- All additions are modulo 2^XLEN; wrap-around is silent. Example: 'hFFFF_FFFC + 4 = 0.
- Redirects (trap/jalr/branch) take effect the next cycle regardless of stall or fetch_ready.
- A redirect in the same cycle as a handshake discards the sequential advance.
- Sequential: pc<=pc+4 only when pc_valid & fetch_ready & !stall. Otherwise pc holds.
- Misalignment: a jalr/branch target with target[1]|target[0] != 0 does not load pc. Instead:
  - misalign<=1
  - misalign_addr<=target
  - state<=FAULT
  - pc_valid<=0
- FAULT: pc holds. jalr, branch and stall are ignored. Only trap or rst exit.
- Simultaneous trap and misaligned jalr: trap wins and no fault is recorded.
- pc changes only on a handshake or a redirect. pc_valid never drops in RUN.

Optional Feature:
- Macro: PC_GEN_HISTORY_EN.
- Defined: a HIST_DEPTH-entry circular buffer records {source_pc, target} on every accepted jalr/branch redirect.
  - For branch, source_pc = branch_pc. For jalr, source_pc = current pc.
  - Writes go to wr_ptr, which then increments and wraps modulo HIST_DEPTH. The oldest entry is overwritten.
  - hist_data = entry[(wr_ptr-1-hist_idx) mod HIST_DEPTH], so idx 0 is the newest. Read is combinational.
  - Traps and faulting redirects are not recorded. Reset zeroes all entries.
- Undefined: hist_idx and hist_data ports are absent; no buffer is built.

Decomposition:
- Package pc_pkg:
  - pc_state_t enum {BOOT, RUN, FAULT}
  - redirect_cause_t enum {SEQ, BRANCH, JALR, TRAP}
  - INSN_BYTES=4
  - default XLEN
- Sub-module pc_history_buf: circular buffer plus pointer. Instantiated only under PC_GEN_HISTORY_EN.

Test Plan:
- Reset: rst=1 for 2 cycles, then 0 -> BOOT one cycle with pc_valid=0; then pc=0, pc_valid=1; with fetch_ready=1 the sequence is 0, 4, 8, 'hC.
- Stall vs. redirect: pc='h20, stall=1 for 3 cycles -> pc stays 'h20. Then stall=1 with branch_taken, branch_pc='h18, offset='hFFFF_FFF8 -> pc='h10 next cycle.
- Priority: trap, jalr (base 'h400, off 4) and branch all in one cycle -> pc='h100.
- Misaligned: jalr with base 'h402, off 0 -> misalign=1, misalign_addr='h402, pc_valid=0, pc holds. A later branch_taken is ignored; trap -> pc='h100, misalign=0, RUN.
- Wrap: XLEN=32, pc='hFFFF_FFFC, handshake -> pc=0, no fault.
- History (feature on): 5 redirects, to targets 'h10, 'h20, 'h30, 'h40, 'h50, with HIST_DEPTH=4 -> idx0 target='h50, idx3 target='h20; 'h10 is overwritten.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the RV32I program-counter generator.
package pc_pkg;

  localparam int DEFAULT_XLEN = 32;
  localparam int INSN_BYTES   = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } pc_state_t;

  typedef enum logic [1:0] {
    SEQ    = 2'd0,
    BRANCH = 2'd1,
    JALR   = 2'd2,
    TRAP   = 2'd3
  } redirect_cause_t;

  // Fetch addresses must be word aligned; any set low bit is a fault.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return |low_bits;
  endfunction

endpackage

// File: rtl/pc_history_buf.sv
// Circular buffer of the most recent accepted redirects, entries {source_pc, target}.
// Read index 0 returns the newest entry; the oldest entry is overwritten when full.
module pc_history_buf
  import pc_pkg::*;
#(
  parameter int XLEN  = DEFAULT_XLEN,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [XLEN-1:0]          wr_src_i,
  input  logic [XLEN-1:0]          wr_tgt_i,
  input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
  output logic [2*XLEN-1:0]        rd_data_o
);

  localparam int PW = $clog2(DEPTH);

  logic [2*XLEN-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_s;

  // Write the new record at the pointer and advance it; DEPTH is a power of 2 so it wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_ptr_q] <= {wr_src_i, wr_tgt_i};
      wr_ptr_q        <= wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_q <= wr_ptr_q;
    end
  end

  // Newest-first combinational read: entry[(wr_ptr - 1 - idx) mod DEPTH].
  always_comb begin
    rd_ptr_s  = wr_ptr_q - PW'(1) - rd_idx_i;
    rd_data_o = mem_q[rd_ptr_s];
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: sequential +4, branch, JALR and trap redirects,
// valid/ready handshake to fetch, misaligned-target fault parking.
// Optional redirect history buffer enabled by defining PC_GEN_HISTORY_EN.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN         = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int              HIST_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  logic                          fetch_ready,
  input  logic                          branch_taken,
  input  logic [XLEN-1:0]               branch_pc,
  input  logic [XLEN-1:0]               branch_offset,
  input  logic                          jalr,
  input  logic [XLEN-1:0]               jalr_base,
  input  logic [XLEN-1:0]               jalr_offset,
  input  logic                          trap,
  output logic [XLEN-1:0]               pc,
  output logic                          pc_valid,
  output logic [XLEN-1:0]               pc_plus4,
  output logic                          misalign,
`ifdef PC_GEN_HISTORY_EN
  output logic [XLEN-1:0]               misalign_addr,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
  output logic [2*XLEN-1:0]             hist_data
`else
  output logic [XLEN-1:0]               misalign_addr
`endif
);

  localparam logic [XLEN-1:0] STEP = XLEN'(INSN_BYTES);

  pc_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pc_valid_q, pc_valid_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] maddr_q, maddr_d;

  redirect_cause_t cause_s;
  logic [XLEN-1:0] pc_plus4_s;
  logic [XLEN-1:0] branch_tgt_s;
  logic [XLEN-1:0] jalr_sum_s;
  logic [XLEN-1:0] jalr_tgt_s;
  logic [XLEN-1:0] tgt_s;
  logic            tgt_misaligned_s;

  // Pick the highest-priority redirect source and its target (all sums wrap silently).
  always_comb begin
    pc_plus4_s   = pc_q + STEP;
    branch_tgt_s = branch_pc + branch_offset;
    jalr_sum_s   = jalr_base + jalr_offset;
    jalr_tgt_s   = {jalr_sum_s[XLEN-1:1], 1'b0};
    cause_s      = SEQ;
    tgt_s        = pc_plus4_s;
    if (trap) begin
      cause_s = TRAP;
      tgt_s   = TRAP_VECTOR;
    end else if (jalr) begin
      cause_s = JALR;
      tgt_s   = jalr_tgt_s;
    end else if (branch_taken) begin
      cause_s = BRANCH;
      tgt_s   = branch_tgt_s;
    end else begin
      cause_s = SEQ;
      tgt_s   = pc_plus4_s;
    end
    tgt_misaligned_s = is_misaligned(tgt_s[1:0]);
  end

  // Next-state and next-pc; a trap is honoured in every state, FAULT ignores everything else.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = misalign_q;
    maddr_d    = maddr_q;
    case (state_q)
      BOOT: begin
        state_d = RUN;
        if (cause_s == TRAP) begin
          pc_d = TRAP_VECTOR;
        end else begin
          pc_d = pc_q;
        end
      end
      RUN: begin
        if (cause_s == TRAP) begin
          pc_d = TRAP_VECTOR;
        end else if (cause_s != SEQ) begin
          if (tgt_misaligned_s) begin
            state_d    = FAULT;
            misalign_d = 1'b1;
            maddr_d    = tgt_s;
          end else begin
            pc_d = tgt_s;
          end
        end else if (pc_valid_q && fetch_ready && !stall) begin
          pc_d = pc_plus4_s;
        end else begin
          pc_d = pc_q;
        end
      end
      FAULT: begin
        if (cause_s == TRAP) begin
          state_d    = RUN;
          pc_d       = TRAP_VECTOR;
          misalign_d = 1'b0;
        end else begin
          state_d = FAULT;
        end
      end
      default: begin
        state_d    = BOOT;
        pc_d       = RESET_VECTOR;
        misalign_d = 1'b0;
      end
    endcase
    pc_valid_d = (state_d == RUN);
  end

  // State and output registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      pc_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      maddr_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      misalign_q <= misalign_d;
      maddr_q    <= maddr_d;
    end
  end

  assign pc            = pc_q;
  assign pc_valid      = pc_valid_q;
  assign misalign      = misalign_q;
  assign misalign_addr = maddr_q;
  assign pc_plus4      = pc_plus4_s;

`ifdef PC_GEN_HISTORY_EN
  logic            hist_we_s;
  logic [XLEN-1:0] hist_src_s;

  // Record only accepted jalr/branch redirects taken in RUN; traps and faults are skipped.
  always_comb begin
    hist_we_s = (state_q == RUN) && ((cause_s == JALR) || (cause_s == BRANCH)) && !tgt_misaligned_s;
    if (cause_s == JALR) begin
      hist_src_s = pc_q;
    end else begin
      hist_src_s = branch_pc;
    end
  end

  pc_history_buf #(
    .XLEN  (XLEN),
    .DEPTH (HIST_DEPTH)
  ) u_hist (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (hist_we_s),
    .wr_src_i  (hist_src_s),
    .wr_tgt_i  (tgt_s),
    .rd_idx_i  (hist_idx),
    .rd_data_o (hist_data)
  );
`endif

endmodule
